// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer in front of a combinational 64-bit ALU: latches a request, holds the ALU
// inputs for a per-opcode settle time, captures {HI,LO} and holds it until the consumer accepts.
module alu_op_sequencer #(
    parameter int BASE_CYCLES = 1,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_hi,
    output logic [31:0] resp_lo,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W  = 16;
    localparam int BASE_L = (BASE_CYCLES < 1) ? 1 : BASE_CYCLES;
    localparam int MUL_L  = (MUL_CYCLES  < 1) ? 1 : MUL_CYCLES;
    localparam int DIV_L  = (DIV_CYCLES  < 1) ? 1 : DIV_CYCLES;

    localparam logic [CNT_W-1:0] BASE_LOAD = CNT_W'(BASE_L - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_L - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_L - 1);

    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b00100;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      alu_a_r;
    logic [31:0]      alu_b_r;
    logic [4:0]       alu_opcode_r;
    logic [31:0]      resp_hi_r;
    logic [31:0]      resp_lo_r;
    logic             resp_err_r;
    logic             resp_valid_r;
    logic             req_ready_r;
    logic             busy_r;

    logic             reject_s;
    logic [CNT_W-1:0] load_s;

    function automatic logic is_legal(input logic [4:0] op);
        logic legal;
        case (op)
            5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b01110, 5'b01111: legal = 1'b1;
            default:            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Request screening and settle-time selection for the opcode being offered
    always_comb begin
        reject_s = 1'b0;
        load_s   = BASE_LOAD;
        if (!is_legal(req_opcode)) begin
            reject_s = 1'b1;
        end else if ((req_opcode == OP_DIV) && (req_b == 32'd0)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
        case (req_opcode)
            OP_MUL:  load_s = MUL_LOAD;
            OP_DIV:  load_s = DIV_LOAD;
            default: load_s = BASE_LOAD;
        endcase
    end

    // Sequencer state, settle counter, ALU input and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= {CNT_W{1'b0}};
            alu_a_r      <= 32'd0;
            alu_b_r      <= 32'd0;
            alu_opcode_r <= 5'd0;
            resp_hi_r    <= 32'd0;
            resp_lo_r    <= 32'd0;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a_r     <= req_a;
                        alu_b_r     <= req_b;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        // Rejected ops bypass the ALU entirely so no undefined result can be captured
                        if (reject_s) begin
                            state_r      <= ST_DONE;
                            resp_hi_r    <= 32'd0;
                            resp_lo_r    <= 32'd0;
                            resp_err_r   <= 1'b1;
                            resp_valid_r <= 1'b1;
                        end else begin
                            state_r      <= ST_EXEC;
                            count_r      <= load_s;
                            alu_opcode_r <= req_opcode;
                        end
                    end
                end
                ST_EXEC: begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r      <= ST_DONE;
                        resp_hi_r    <= alu_result[63:32];
                        resp_lo_r    <= alu_result[31:0];
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= 1'b1;
                        alu_opcode_r <= 5'd0;
                    end else begin
                        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    alu_opcode_r <= 5'd0;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;
    assign resp_valid = resp_valid_r;
    assign resp_hi    = resp_hi_r;
    assign resp_lo    = resp_lo_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sits between the bus/control unit and the combinational 64-bit-result ALU.
- Accepts one operation request per handshake, registers the operands and opcode, and drives the ALU inputs stably.
- Waits a per-opcode number of settle cycles, then captures the 64-bit result into HI/LO result registers.
- Holds the result for the consumer until it is accepted.
- Screens out illegal opcodes and division by zero, so the ALU never produces an undefined result into the datapath.

Parameters:
BASE_CYCLES, 1, settle cycles for add/sub/logic/shift/rotate/neg/not (values <1 treated as 1)
MUL_CYCLES, 4, settle cycles for opcode 00011 (values <1 treated as 1)
DIV_CYCLES, 8, settle cycles for opcode 00100 (values <1 treated as 1)

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request (high only in IDLE)
req_opcode  in  5  ALU opcode (00001..01011, 01110, 01111 legal)
req_a  in  32  operand A (signed for SHRA/MUL/DIV)
req_b  in  32  operand B / shift or rotate amount
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_opcode  out  5  opcode to ALU; 00000 whenever not in EXEC
alu_result  in  64  ALU result {HI,LO}
resp_valid  out  1  result held and valid
resp_ready  in  1  consumer accepts result
resp_hi  out  32  captured result[63:32]
resp_lo  out  32  captured result[31:0]
resp_err  out  1  1 = illegal opcode or divide by zero; resp_hi/resp_lo = 0
busy  out  1  high in EXEC or DONE

Behaviour:
States: IDLE, EXEC, DONE. Next state, counter and all registers update on the rising edge of clk.

Reset (reset=1 at an edge; wins over every other event, including mid-EXEC or mid-DONE):
- state=IDLE, counter=0.
- alu_a=alu_b=0, alu_opcode=0.
- resp_hi=resp_lo=0, resp_err=0, resp_valid=0, busy=0.
- Any in-flight operation is dropped; no response is produced for it.

IDLE:
- req_ready=1.
- On an edge with req_valid=1, latch req_a/req_b/req_opcode into alu_a/alu_b and an internal op register.
- Illegal opcode (00000, 01100, 01101, 10000-11111):
  - Next state DONE; resp_err=1, resp_hi=resp_lo=0.
  - The ALU is never driven.
- Opcode 00100 with req_b==0:
  - Same as illegal: DONE, resp_err=1, result 0.
- Otherwise:
  - Next state EXEC; counter = L-1.
  - L = MUL_CYCLES for 00011, DIV_CYCLES for 00100, BASE_CYCLES for all other legal opcodes.

EXEC:
- alu_opcode = latched op; alu_a/alu_b held constant; req_ready=0.
- At each edge: if counter==0, capture {resp_hi,resp_lo} <= alu_result, set resp_err=0 and go to DONE; else decrement counter.
- Exactly L cycles are spent in EXEC.

DONE:
- resp_valid=1; resp_hi/resp_lo/resp_err held stable; alu_opcode=0.
- On an edge with resp_ready=1, go to IDLE.
- resp_ready may be held high in advance; the response then lasts exactly 1 cycle.

Latency and throughput:
- Legal op: resp_valid rises L+1 cycles after the accept edge.
- Illegal op or divide by zero: resp_valid rises 1 cycle after the accept edge.
- No request is accepted in the cycle DONE exits; the next accept is possible one cycle later. Maximum throughput is 1 op per L+2 cycles.

Other rules:
- req_* inputs are ignored outside IDLE; a held req_valid is not double-accepted.
- Result registers keep their last value after DONE exits, until the next capture or reset.

Test Plan:
- Add: req A=5, B=7, op 00001, BASE_CYCLES=1, resp_ready=1 -> resp_valid 2 cycles after accept; resp_lo=12, resp_hi=0, resp_err=0; alu_opcode=00001 for exactly 1 cycle.
- Multiply: A=0x0001_0000, B=0x0001_0000, op 00011, MUL_CYCLES=4 -> alu_opcode=00011 for 4 cycles; resp_hi=1, resp_lo=0 at cycle 5 after accept.
- Divide by zero / illegal: op 00100 with B=0, then op 01100 -> each gives resp_valid 1 cycle after accept, resp_err=1, resp_hi=resp_lo=0; alu_opcode stays 00000 throughout.
- Backpressure: SHL A=1, B=4, resp_ready held low for 3 cycles after resp_valid -> resp_lo=16 held stable, req_ready=0, a new req_valid is ignored; resp_ready=1 -> IDLE next cycle, then the pending request is accepted.
- Reset mid-op: DIV A=100, B=7, assert reset in the 3rd EXEC cycle -> next cycle IDLE; all outputs at reset values; no resp_valid. A following DIV 100/7 yields resp_lo/resp_hi per the ALU divide encoding, resp_err=0.
- Back-to-back: two ops with req_valid held high, resp_ready=1 -> second accept occurs exactly 1 cycle after DONE exits; each op is accepted exactly once.
